global_chain_checker: RTL and testbench
=======================================

Name: global_chain_checker

Overview:
- Parametrised successor to the single-lane global-clock register chain.
- A WIDTH-lane, DEPTH-stage register chain is driven by an on-chip 16-bit LFSR pattern generator. A second LFSR checks the tail against the expected sequence.
- Hardware tests of global clock distribution report pass/fail and a saturating error count, not just a raw tail bit.
- Stage registers are individual, with per-stage keep, so placement constraints can pin each stage to distant sites across the die.

Parameters:
- WIDTH, 4, lanes per stage (1..16).
- DEPTH, 4, chain stages (>=1).
- SEED, 16'hACE1, LFSR start value (nonzero).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin test (IDLE only).
- stop  in  1  abort/stop test.
- inject  in  1  flip lane 0 at chain input this cycle.
- q  out  WIDTH  chain tail (stage DEPTH-1).
- busy  out  1  state != IDLE.
- checking  out  1  state == CHECK.
- err  out  1  sticky mismatch flag.
- err_cnt  out  ERR_W  saturating mismatch count.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all stages=0; q=0; busy=0; checking=0; err=0; err_cnt=0.
  - gen=SEED, chk=SEED, fill_cnt=0.
- LFSR step: next = {l[14:0], l[15]^l[13]^l[12]^l[10]}. Lane data = l[WIDTH-1:0].
- IDLE:
  - Chain and LFSRs hold.
  - start=1: next state FILL; gen<=SEED, chk<=SEED, fill_cnt<=0, err<=0, err_cnt<=0.
- FILL and CHECK (running):
  - Every edge: stage[0]<=gen[WIDTH-1:0] ^ {0..,inject}; stage[i]<=stage[i-1]; gen<=next(gen).
- FILL:
  - fill_cnt increments each edge.
  - At the edge where fill_cnt==DEPTH-1, go to CHECK.
  - FILL lasts exactly DEPTH cycles.
- CHECK:
  - Every cycle compare q with chk[WIDTH-1:0], then chk<=next(chk).
  - On mismatch: err<=1; err_cnt<=err_cnt+1, saturating at all-ones.
  - In the first CHECK cycle, q==SEED[WIDTH-1:0].
- stop=1 while running: next state IDLE; chain, LFSRs and counters freeze; err/err_cnt keep their values until the next start.
- Simultaneous start and stop: stop wins when running. In IDLE, start wins (stop is ignored).
- start while running: ignored.
- inject in CHECK: exactly one mismatch, counted at the edge DEPTH cycles after the inject edge. inject in FILL is also counted if it reaches the tail during CHECK. inject in IDLE has no effect.
- Latency: start edge to checking=1 is DEPTH+1 edges.
- resetn asserted mid-operation: immediate return to reset values, no partial count retained.

Decomposition:
- Package global_chain_pkg holds:
  - state typedef (IDLE, FILL, CHECK);
  - LFSR tap constant;
  - lfsr16_next function;
  - default SEED.
- Sub-module global_lfsr16 (clk, resetn, load, adv, value), instantiated twice: generator and checker.
- Chain stages are a generate loop in the top module.

Test Plan:
- Reset, WIDTH=4 DEPTH=4: hold resetn=0 -> all outputs 0. Release; idle 10 cycles -> q stays 0, busy=0.
- start pulse -> busy=1 next cycle; checking=1 after 5 edges; first CHECK q=4'h1; q then follows the LFSR low nibble; 100 cycles with err=0, err_cnt=0.
- inject single cycle in CHECK -> err_cnt=1 and err=1 exactly 4 cycles after the inject edge; no further increments.
- ERR_W=2: five injects spaced 8 cycles apart -> err_cnt saturates at 2'd3, err=1.
- stop mid-FILL (cycle 2) -> busy=0, chain frozen. New start -> err/err_cnt cleared, checking after DEPTH+1 edges, no errors.
- resetn pulsed low mid-CHECK with err_cnt=3 -> outputs return to 0 asynchronously. After release, state IDLE until start.

Source files
------------

// File: rtl/global_chain_pkg.sv
// Shared types and LFSR helpers for the global-clock register chain checker.
package global_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2
    } chain_state_t;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/global_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload to SEED and step enable.
module global_lfsr16
    import global_chain_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        adv,
    output logic [15:0] value
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (adv) begin
            value <= lfsr16_next(value);
        end
    end

endmodule

// File: rtl/global_chain_checker.sv
// WIDTH-lane, DEPTH-stage global-clock register chain fed by a generator LFSR
// and checked at the tail by a second LFSR, with sticky error and saturating count.
module global_chain_checker
    import global_chain_pkg::*;
#(
    parameter int          WIDTH = 4,
    parameter int          DEPTH = 4,
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          ERR_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             inject,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             checking,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        if (&c) return c;
        return c + 1'b1;
    endfunction

    chain_state_t     state, state_next;
    logic [CNT_W-1:0] fill_cnt;
    logic [15:0]      gen_val, chk_val;
    logic             launch, run, check_adv, fill_done, mismatch;
    logic [WIDTH-1:0] stage_in;
    logic [WIDTH-1:0] taps [DEPTH];
    logic             unused_bits;

    // A stop edge freezes everything, so every advance is gated by !stop.
    assign launch    = (state == IDLE) && start;
    assign run       = (state != IDLE) && !stop;
    assign check_adv = (state == CHECK) && !stop;
    assign fill_done = (fill_cnt == CNT_W'(DEPTH - 1));
    assign mismatch  = (q != chk_val[WIDTH-1:0]);
    assign stage_in  = gen_val[WIDTH-1:0] ^ WIDTH'(inject);

    assign busy        = (state != IDLE);
    assign checking    = (state == CHECK);
    assign unused_bits = ^{gen_val, chk_val};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL: begin
                if (stop)           state_next = IDLE;
                else if (fill_done) state_next = CHECK;
            end
            CHECK:   if (stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_cnt <= '0;
        end else if (launch) begin
            fill_cnt <= '0;
        end else if ((state == FILL) && !stop) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (launch) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (check_adv && mismatch) begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
        end
    end

    global_lfsr16 #(.SEED(SEED)) u_gen (
        .clk    (clk),
        .resetn (resetn),
        .load   (launch),
        .adv    (run),
        .value  (gen_val)
    );

    global_lfsr16 #(.SEED(SEED)) u_chk (
        .clk    (clk),
        .resetn (resetn),
        .load   (launch),
        .adv    (check_adv),
        .value  (chk_val)
    );

    // Each stage is its own kept register so placement can pin it anywhere on the die.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        (* keep = "true" *) logic [WIDTH-1:0] data_p;
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_head
            assign d = stage_in;
        end else begin : g_body
            assign d = taps[i-1];
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                data_p <= '0;
            end else if (run) begin
                data_p <= d;
            end
        end

        assign taps[i] = data_p;
    end

    assign q = taps[DEPTH-1];

endmodule

// File: tb/tb_global_chain_checker.sv
// Scoreboard bench: a queue-based reference model predicts every cycle, a negedge monitor compares.
module tb_global_chain_checker;

    localparam int          W    = 4;
    localparam int          D    = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0, stop = 1'b0, inject = 1'b0;

    logic [W-1:0] q, q_s;
    logic         busy, busy_s, checking, checking_s, err, err_s;
    logic [7:0]   err_cnt;
    logic [1:0]   err_cnt_s;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         checking;
        logic         err;
        logic [7:0]   cnt8;
        logic [1:0]   cnt2;
    } exp_t;

    exp_t sbq[$];

    // Reference model state: chain as a queue (front = stage 0).
    int           mode;   // 0 idle, 1 fill, 2 check
    int           fills;
    logic [15:0]  mgen, mchk;
    logic [W-1:0] chain[$];
    int           errc;
    logic         errf;

    always #5 clk = ~clk;

    global_chain_checker #(.WIDTH(W), .DEPTH(D), .SEED(SEED), .ERR_W(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .inject(inject),
        .q(q), .busy(busy), .checking(checking), .err(err), .err_cnt(err_cnt)
    );

    global_chain_checker #(.WIDTH(W), .DEPTH(D), .SEED(SEED), .ERR_W(2)) dut_sat (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .inject(inject),
        .q(q_s), .busy(busy_s), .checking(checking_s), .err(err_s), .err_cnt(err_cnt_s)
    );

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mode  = 0;
        fills = 0;
        mgen  = SEED;
        mchk  = SEED;
        chain.delete();
        for (int k = 0; k < D; k++) chain.push_back('0);
        errc  = 0;
        errf  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic i);
        if (mode == 0) begin
            if (s) begin
                mode = 1; fills = 0; mgen = SEED; mchk = SEED; errc = 0; errf = 1'b0;
            end
        end else if (p) begin
            mode = 0;
        end else begin
            if (mode == 2) begin
                if (chain[D-1] != mchk[W-1:0]) begin
                    errc++;
                    errf = 1'b1;
                end
                mchk = nxt(mchk);
            end
            chain.push_front(mgen[W-1:0] ^ {{(W-1){1'b0}}, i});
            void'(chain.pop_back());
            mgen = nxt(mgen);
            if (mode == 1) begin
                fills++;
                if (fills == D) mode = 2;
            end
        end
    endtask

    // Drive one cycle: predict, push, then return just after the following negedge.
    task automatic do_step(input logic s, input logic p, input logic i);
        exp_t e;
        start = s; stop = p; inject = i;
        if (!resetn) model_reset();
        else model_step(s, p, i);
        e.q        = chain[D-1];
        e.busy     = (mode != 0);
        e.checking = (mode == 2);
        e.err      = errf;
        e.cnt8     = (errc > 255) ? 8'hFF : 8'(errc);
        e.cnt2     = (errc > 3) ? 2'd3 : 2'(errc);
        sbq.push_back(e);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("dut8_q",        32'(q),          32'(e.q));
            check("dut8_busy",     32'(busy),       32'(e.busy));
            check("dut8_checking", 32'(checking),   32'(e.checking));
            check("dut8_err",      32'(err),        32'(e.err));
            check("dut8_err_cnt",  32'(err_cnt),    32'(e.cnt8));
            check("dut2_q",        32'(q_s),        32'(e.q));
            check("dut2_busy",     32'(busy_s),     32'(e.busy));
            check("dut2_checking", 32'(checking_s), 32'(e.checking));
            check("dut2_err",      32'(err_s),      32'(e.err));
            check("dut2_err_cnt",  32'(err_cnt_s),  32'(e.cnt2));
        end
    end

    initial begin
        logic [W-1:0] qf;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_q", 32'(q), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_err_cnt", 32'(err_cnt), 0);
        for (int k = 0; k < 3; k++) do_step(1'b0, 1'b0, 1'b0);

        // Idle after release: stop and inject have no effect.
        resetn = 1'b1;
        for (int k = 0; k < 10; k++)
            do_step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("idle_q", 32'(q), 0);

        // Start and fill latency.
        do_step(1'b1, 1'b0, 1'b0);
        check("start_busy", 32'(busy), 1);
        for (int k = 0; k < D - 1; k++) do_step(1'b0, 1'b0, 1'b0);
        check("latency_not_yet", 32'(checking), 0);
        do_step(1'b0, 1'b0, 1'b0);
        check("latency_checking", 32'(checking), 1);
        check("first_check_q", 32'(q), 32'h1);

        // Clean run; start while running is ignored.
        for (int k = 0; k < 100; k++)
            do_step(1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        check("clean_err", 32'(err), 0);
        check("clean_err_cnt", 32'(err_cnt), 0);

        // Single inject counted exactly DEPTH edges later.
        do_step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < D - 1; k++) do_step(1'b0, 1'b0, 1'b0);
        check("inject_early", 32'(err_cnt), 0);
        do_step(1'b0, 1'b0, 1'b0);
        check("inject_cnt", 32'(err_cnt), 1);
        check("inject_err", 32'(err), 1);
        for (int k = 0; k < 10; k++) do_step(1'b0, 1'b0, 1'b0);
        check("inject_no_more", 32'(err_cnt), 1);

        // Five more injects: 2-bit counter saturates.
        for (int n = 0; n < 5; n++) begin
            do_step(1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 7; k++) do_step(1'b0, 1'b0, 1'b0);
        end
        check("sat_cnt2", 32'(err_cnt_s), 3);
        check("sat_cnt8", 32'(err_cnt), 6);

        // Stop, restart, stop mid-fill, then a clean restart.
        do_step(1'b0, 1'b1, 1'b0);
        check("stop_busy", 32'(busy), 0);
        check("stop_keeps_cnt", 32'(err_cnt), 6);
        do_step(1'b1, 1'b0, 1'b0);
        do_step(1'b0, 1'b0, 1'b0);
        do_step(1'b0, 1'b1, 1'b0);
        check("stop_fill_busy", 32'(busy), 0);
        qf = q;
        for (int k = 0; k < 5; k++) do_step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check("frozen_q", 32'(q), 32'(qf));
        do_step(1'b1, 1'b1, 1'b0);
        check("restart_err_clear", 32'(err), 0);
        check("restart_cnt_clear", 32'(err_cnt), 0);
        for (int k = 0; k < D; k++) do_step(1'b0, 1'b0, 1'b0);
        check("restart_checking", 32'(checking), 1);
        for (int k = 0; k < 20; k++) do_step(1'b0, 1'b0, 1'b0);
        check("restart_clean", 32'(err_cnt), 0);

        // Random control traffic.
        for (int k = 0; k < 400; k++)
            do_step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 7) == 0));

        // Accumulate three errors then reset asynchronously mid-cycle.
        do_step(1'b0, 1'b1, 1'b0);
        do_step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < D; k++) do_step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            do_step(1'b0, 1'b0, 1'b1);
            do_step(1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 6; k++) do_step(1'b0, 1'b0, 1'b0);
        check("pre_reset_cnt", 32'(err_cnt), 3);
        #2;
        resetn = 1'b0;
        #1;
        check("async_q", 32'(q), 0);
        check("async_busy", 32'(busy), 0);
        check("async_checking", 32'(checking), 0);
        check("async_err", 32'(err), 0);
        check("async_err_cnt", 32'(err_cnt), 0);
        check("async_err_cnt2", 32'(err_cnt_s), 0);
        model_reset();
        for (int k = 0; k < 2; k++) do_step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++)
            do_step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("post_reset_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
